edit_mod_counter: RTL
=====================

// Module: edit_mod_counter
// PURPOSE
//  Parametrised modulo-N time-field counter (minutes, seconds, hours) with front-panel digit editing.
//  Counts tick pulses from the lower stage and emits a 1-cycle carry on wrap to clock the next stage.
//  In edit mode, falling edges of key_plus/key_minus adjust the ones or tens digit.
//  Edits apply only when this field's screen and edit position are selected.
//  Fully synchronous; all key and tick inputs are sampled on clk.
// PARAMETERS
//  MODULUS     60  count range 0..MODULUS-1; legal 2..100
//  WIDTH       6   value width; must satisfy 2**WIDTH >= MODULUS
//  SCREEN_ID   0   screen code on which this field is editable
//  POS_ONES    3   edit_pos code selecting the ones digit
//  POS_TENS    2   edit_pos code selecting the tens digit
//  RPT_DELAY   50  (HOLD_REPEAT_EN only) held-key cycles before first repeat
//  RPT_PERIOD  10  (HOLD_REPEAT_EN only) cycles between repeats
// PORTS
//  clk        in   1      clock
//  reset      in   1      synchronous reset, active-high
//  tick       in   1      count-enable pulse, 1 cycle, from lower stage
//  key_plus   in   1      increment button, active-low, already debounced
//  key_minus  in   1      decrement button, active-low, already debounced
//  edit_mode  in   1      1 = editing, 0 = running
//  edit_pos   in   3      selected digit position
//  screen     in   2      currently displayed screen
//  value      out  WIDTH  current count, binary
//  carry      out  1      registered 1-cycle pulse on wrap MODULUS-1 -> 0
//  at_max     out  1      combinational: value == MODULUS-1
// BEHAVIOUR
//  - Reset: value=0, carry=0, key history registers=1 (released), repeat counter=0.
//  - Key edge: press = key==0 && key_prev==1 at a clk edge; key_prev is updated every cycle.
//  - Edit is qualified when edit_mode==1, screen==SCREEN_ID and edit_pos is POS_ONES or POS_TENS.
//    Unqualified presses are ignored.
//  - Latency: an event sampled at edge N produces the new value/carry after edge N (registered).
//  - Priority per cycle: reset > tick > plus press > minus press. The lower-priority events are dropped.
//  - Running (edit_mode==0):
//    - tick -> value = (value==MODULUS-1) ? 0 : value+1.
//    - carry=1 for exactly that cycle on wrap; otherwise carry=0.
//  - Editing:
//    - tick is ignored and carry stays 0 (no carry storm while editing).
//    - Edits never carry into the next stage.
//  - Edit arithmetic: o = value%10, t = value-o, M = MODULUS-1.
//    - ones +: if o==9 or value==M -> t; else value+1.
//    - ones -: if o==0 -> min(t+9, M); else value-1.
//    - tens +: if value+10 > M -> o; else value+10.
//    - tens -: if value < 10 -> ((M-o)/10)*10+o; else value-10.
//  - Every result lies in 0..M. Values outside this range are unreachable; do not assert on them.
//  - Mode change mid-operation:
//    - edit_mode 1->0 keeps value; counting resumes from the next tick.
//    - 0->1 on a tick cycle: the tick is ignored.
//  - Reset asserted mid-hold: clears history; a key still held low after reset is not a press until released.
// CONFIGURATION
//  HOLD_REPEAT_EN defined:
//    - A qualified key held low for RPT_DELAY cycles after its press generates a repeat press.
//    - Further repeats follow every RPT_PERIOD cycles until release.
//    - Repeats follow the same arithmetic and priority rules as a press.
//    - Releasing the key, or leaving the qualifying condition, clears the repeat counter.
//  HOLD_REPEAT_EN undefined:
//    - Only the press edge acts; RPT_* parameters are unused; no repeat logic is synthesised.
// TESTING
//  1. MODULUS=60, value=59, tick, edit_mode=0 -> value=0 and carry=1 for 1 cycle; next cycle carry=0.
//  2. MODULUS=24, edit on ones, value=23, plus press -> 20; minus press at 20 -> 23.
//  3. MODULUS=24, tens selected, value=5, minus press -> 15; at value=18, plus press -> 8.
//  4. tick and plus press in the same cycle, edit_mode=0 -> value+1, key ignored.
//     Same with screen!=SCREEN_ID and edit_mode=1 -> no change.
//  5. edit_mode=1, 100 ticks -> value unchanged, carry never 1.
//     reset while key_plus held -> value=0, no press until key released and pressed again.
//  6. HOLD_REPEAT_EN, RPT_DELAY=5, RPT_PERIOD=3, ones selected, value=0, hold 12 cycles -> value=4.
//     (Press at cycle 0, repeats at cycles 5, 8, 11.)

Source files
------------

// File: rtl/edit_mod_counter.sv
// Modulo-N time-field counter with front-panel ones/tens digit editing.
// Latency: value/carry update one clk after the sampled tick or key event.
// Backpressure: none; tick and key inputs are sampled every cycle, carry is a 1-cycle pulse.
// Optional feature macro: HOLD_REPEAT_EN (auto-repeat while a qualified key is held).
module edit_mod_counter #(
  parameter int MODULUS    = 60,
  parameter int WIDTH      = 6,
  parameter int SCREEN_ID  = 0,
  parameter int POS_ONES   = 3,
  parameter int POS_TENS   = 2,
  parameter int RPT_DELAY  = 50,
  parameter int RPT_PERIOD = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             key_plus,
  input  logic             key_minus,
  input  logic             edit_mode,
  input  logic [2:0]       edit_pos,
  input  logic [1:0]       screen,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             at_max
);

  // Edit arithmetic runs wider than WIDTH so value+10 cannot overflow.
  localparam int EW = WIDTH + 5;
  localparam logic [WIDTH-1:0] MW  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] W1  = WIDTH'(1);
  localparam logic [EW-1:0]    M   = EW'(MODULUS - 1);
  localparam logic [EW-1:0]    C0  = EW'(0);
  localparam logic [EW-1:0]    C1  = EW'(1);
  localparam logic [EW-1:0]    C9  = EW'(9);
  localparam logic [EW-1:0]    C10 = EW'(10);

  logic          kp_prev, km_prev;
  logic          kp_arm, km_arm;
  logic          press_p, press_m;
  logic          rpt_p, rpt_m;
  logic          sel_ones, sel_tens, qualified;
  logic          act_plus, act_minus;
  logic [EW-1:0] v, o, t;
  logic [EW-1:0] ones_up, ones_dn, tens_up, tens_dn, ones_dn_raw, tens_dn_low;
  logic [EW-1:0] edit_nx;

  // A key held through reset stays disarmed until it has been seen released,
  // so the history register alone cannot fake a press edge after reset.
  assign press_p = ~key_plus  & kp_prev & kp_arm;
  assign press_m = ~key_minus & km_prev & km_arm;

  assign sel_ones  = (edit_pos == 3'(POS_ONES));
  assign sel_tens  = (edit_pos == 3'(POS_TENS));
  assign qualified = edit_mode && (screen == 2'(SCREEN_ID)) && (sel_ones || sel_tens);

  // Plus wins over minus when both act in the same cycle.
  assign act_plus  = qualified & (press_p | rpt_p);
  assign act_minus = qualified & (press_m | rpt_m) & ~act_plus;

  assign v           = {5'd0, value};
  assign o           = v % C10;
  assign t           = v - o;
  assign ones_dn_raw = t + C9;
  assign tens_dn_low = ((M - o) / C10) * C10 + o;

  assign ones_up = ((o == C9) || (v == M)) ? t : v + C1;
  assign ones_dn = (o == C0) ? ((ones_dn_raw > M) ? M : ones_dn_raw) : v - C1;
  assign tens_up = ((v + C10) > M) ? o : v + C10;
  assign tens_dn = (v < C10) ? tens_dn_low : v - C10;

  // Select the edited digit result; holds the current value when no edit acts.
  always_comb begin
    edit_nx = v;
    if (act_plus) begin
      edit_nx = sel_ones ? ones_up : tens_up;
    end else if (act_minus) begin
      edit_nx = sel_ones ? ones_dn : tens_dn;
    end
  end

  assign at_max = (value == MW);

  // Count/edit register: tick while running beats any edit; ticks in edit mode are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      value   <= '0;
      carry   <= 1'b0;
      kp_prev <= 1'b1;
      km_prev <= 1'b1;
      kp_arm  <= key_plus;
      km_arm  <= key_minus;
    end else begin
      kp_prev <= key_plus;
      km_prev <= key_minus;
      kp_arm  <= kp_arm | key_plus;
      km_arm  <= km_arm | key_minus;
      carry   <= 1'b0;
      if (tick && !edit_mode) begin
        value <= (value == MW) ? '0 : value + W1;
        carry <= (value == MW);
      end else if (act_plus || act_minus) begin
        value <= edit_nx[WIDTH-1:0];
      end
    end
  end

`ifdef HOLD_REPEAT_EN
  localparam logic [15:0] RD = 16'(RPT_DELAY);
  localparam logic [15:0] RL = 16'(RPT_DELAY - RPT_PERIOD + 1);

  logic [15:0] rpt_cnt;
  logic        held;
  logic        rpt_fire;

  // rpt_cnt==0 means idle; a press starts it at 1 so it equals the cycles held.
  assign held     = qualified & (~key_plus | ~key_minus);
  assign rpt_fire = held & (rpt_cnt == RD) & ~(press_p | press_m);
  assign rpt_p    = rpt_fire & ~key_plus;
  assign rpt_m    = rpt_fire & key_plus & ~key_minus;

  // Hold timer: first repeat after RPT_DELAY, then every RPT_PERIOD until release.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt <= '0;
    end else if (!held) begin
      rpt_cnt <= '0;
    end else if (press_p || press_m) begin
      rpt_cnt <= 16'd1;
    end else if (rpt_cnt == RD) begin
      rpt_cnt <= RL;
    end else if (rpt_cnt != 16'd0) begin
      rpt_cnt <= rpt_cnt + 16'd1;
    end
  end
`else
  assign rpt_p = 1'b0;
  assign rpt_m = 1'b0;
`endif

endmodule
